fp_divider: RTL

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_div_step.sv | 21 ++
 rtl/fp_divider.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 arithmetic blocks (divider, multiplier).
// Exponents are carried unbiased in a 10-bit signed field throughout.
package fp_pkg;

   typedef enum logic [3:0] {
      GET_A   = 4'd0,
      GET_B   = 4'd1,
      UNPACK  = 4'd2,
      SPECIAL = 4'd3,
      NORM_A  = 4'd4,
      NORM_B  = 4'd5,
      DIV     = 4'd6,
      POST    = 4'd7,
      NORM2   = 4'd8,
      ROUND   = 4'd9,
      PACK    = 4'd10,
      PUT_Z   = 4'd11
   } fp_state_e;

   localparam logic signed [9:0] FP_BIAS = 10'sd127;
   localparam logic signed [9:0] FP_EMIN = -10'sd126;
   localparam logic signed [9:0] FP_EMAX = 10'sd127;
   localparam logic [31:0]       FP_QNAN = 32'h7FC00000;
   localparam logic [31:0]       FP_INF  = 32'h7F800000;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: shift a quotient bit in, conditionally subtract
// the divisor, then shift the partial remainder left for the next step.
module fp_div_step (
   input  logic [24:0] rem_i,
   input  logic [23:0] div_i,
   input  logic [26:0] quot_i,
   output logic [24:0] rem_o,
   output logic [26:0] quot_o
);

   logic        ge;
   logic [24:0] rem_sub;

   assign ge      = (rem_i >= {1'b0, div_i});
   assign rem_sub = ge ? (rem_i - {1'b0, div_i}) : rem_i;

   // rem_sub is below the divisor, so its top bit is always zero before the shift.
   assign rem_o  = rem_sub << 1;
   assign quot_o = (quot_i << 1) | {26'd0, ge};

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 binary32 divider with strobe/ack handshakes on both
// operands and the result; one restoring quotient bit is produced per cycle.
module fp_divider
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] in_A,
   input  logic        strb_A,
   output logic        in_A_ack,
   input  logic [31:0] in_B,
   input  logic        strb_B,
   output logic        in_B_ack,
   output logic [31:0] output_quot,
   output logic        output_quot_stb,
   input  logic        out_quot_ack,
   output fp_state_e   dbg_state_o
);

   // Handshake: an operand or result moves on a rising edge where the
   // producer's strobe and the receiver's ack/stb are both high.
   localparam logic signed [9:0] E_SPECIAL = FP_EMAX + 10'sd1;
   localparam logic signed [9:0] E_DENORM  = FP_EMIN - 10'sd1;

   fp_state_e          state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d;
   logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d;
   logic [23:0]        z_m_q, z_m_d;
   logic signed [9:0]  z_e_q, z_e_d;
   logic               z_s_q, z_s_d;
   logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
   logic [24:0]        rem_q, rem_d;
   logic [26:0]        quot_q, quot_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [31:0]        z_q, z_d;
   logic               in_a_ack_q, in_a_ack_d, in_b_ack_q, in_b_ack_d;
   logic               stb_q, stb_d;
   logic [31:0]        out_q, out_d;

   logic [24:0]        step_rem;
   logic [26:0]        step_quot;
   logic [24:0]        round_sum;
   logic [7:0]         exp_biased;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   fp_div_step u_step (
      .rem_i  (rem_q),
      .div_i  (b_m_q),
      .quot_i (quot_q),
      .rem_o  (step_rem),
      .quot_o (step_quot)
   );

   assign a_nan  = (a_e_q == E_SPECIAL) && (a_m_q != 24'd0);
   assign b_nan  = (b_e_q == E_SPECIAL) && (b_m_q != 24'd0);
   assign a_inf  = (a_e_q == E_SPECIAL) && (a_m_q == 24'd0);
   assign b_inf  = (b_e_q == E_SPECIAL) && (b_m_q == 24'd0);
   assign a_zero = (a_e_q == E_DENORM) && (a_m_q == 24'd0);
   assign b_zero = (b_e_q == E_DENORM) && (b_m_q == 24'd0);

   assign round_sum  = {1'b0, z_m_q} + 25'd1;
   assign exp_biased = 8'(z_e_q + FP_BIAS);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      a_m_d      = a_m_q;
      b_m_d      = b_m_q;
      a_e_d      = a_e_q;
      b_e_d      = b_e_q;
      z_m_d      = z_m_q;
      z_e_d      = z_e_q;
      z_s_d      = z_s_q;
      guard_d    = guard_q;
      round_d    = round_q;
      sticky_d   = sticky_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      cnt_d      = cnt_q;
      z_d        = z_q;
      in_a_ack_d = in_a_ack_q;
      in_b_ack_d = in_b_ack_q;
      stb_d      = stb_q;
      out_d      = out_q;

      case (state_q)
         GET_A: begin
            in_a_ack_d = 1'b1;
            if (in_a_ack_q && strb_A) begin
               a_d        = in_A;
               in_a_ack_d = 1'b0;
               state_d    = GET_B;
            end
         end
         GET_B: begin
            in_b_ack_d = 1'b1;
            if (in_b_ack_q && strb_B) begin
               b_d        = in_B;
               in_b_ack_d = 1'b0;
               state_d    = UNPACK;
            end
         end
         UNPACK: begin
            a_m_d   = {1'b0, a_q[22:0]};
            b_m_d   = {1'b0, b_q[22:0]};
            a_e_d   = $signed({2'b00, a_q[30:23]}) - FP_BIAS;
            b_e_d   = $signed({2'b00, b_q[30:23]}) - FP_BIAS;
            z_s_d   = a_q[31] ^ b_q[31];
            state_d = SPECIAL;
         end
         SPECIAL: begin
            state_d = PUT_Z;
            if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
               z_d = FP_QNAN;
            end else if (a_inf || b_zero) begin
               z_d = {z_s_q, FP_INF[30:0]};
            end else if (b_inf || a_zero) begin
               z_d = {z_s_q, 31'd0};
            end else begin
               // Denormals take the minimum exponent with no hidden bit.
               if (a_e_q == E_DENORM) a_e_d = FP_EMIN;
               else                   a_m_d = {1'b1, a_m_q[22:0]};
               if (b_e_q == E_DENORM) b_e_d = FP_EMIN;
               else                   b_m_d = {1'b1, b_m_q[22:0]};
               state_d = NORM_A;
            end
         end
         NORM_A: begin
            if (a_m_q[23]) begin
               state_d = NORM_B;
            end else begin
               a_m_d = a_m_q << 1;
               a_e_d = a_e_q - 10'sd1;
            end
         end
         NORM_B: begin
            if (b_m_q[23]) begin
               rem_d   = {1'b0, a_m_q};
               quot_d  = 27'd0;
               cnt_d   = 5'd0;
               z_e_d   = a_e_q - b_e_q;
               state_d = DIV;
            end else begin
               b_m_d = b_m_q << 1;
               b_e_d = b_e_q - 10'sd1;
            end
         end
         DIV: begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd26) state_d = POST;
         end
         POST: begin
            if (quot_q[26]) begin
               z_m_d    = quot_q[26:3];
               guard_d  = quot_q[2];
               round_d  = quot_q[1];
               sticky_d = quot_q[0] | (rem_q != 25'd0);
            end else begin
               z_m_d    = quot_q[25:2];
               guard_d  = quot_q[1];
               round_d  = quot_q[0];
               sticky_d = (rem_q != 25'd0);
               z_e_d    = z_e_q - 10'sd1;
            end
            state_d = NORM2;
         end
         NORM2: begin
            // Denormalise towards the minimum exponent, keeping the lost bits for rounding.
            if (z_e_q < FP_EMIN) begin
               z_m_d    = z_m_q >> 1;
               z_e_d    = z_e_q + 10'sd1;
               guard_d  = z_m_q[0];
               round_d  = guard_q;
               sticky_d = sticky_q | round_q;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
               if (round_sum[24]) begin
                  z_m_d = 24'h800000;
                  z_e_d = z_e_q + 10'sd1;
               end else begin
                  z_m_d = round_sum[23:0];
               end
            end
            state_d = PACK;
         end
         PACK: begin
            if (z_e_q > FP_EMAX) begin
               z_d = {z_s_q, FP_INF[30:0]};
            end else if ((z_e_q == FP_EMIN) && !z_m_q[23]) begin
               z_d = {z_s_q, 8'd0, z_m_q[22:0]};
            end else begin
               z_d = {z_s_q, exp_biased, z_m_q[22:0]};
            end
            state_d = PUT_Z;
         end
         PUT_Z: begin
            stb_d = 1'b1;
            out_d = z_q;
            if (stb_q && out_quot_ack) begin
               stb_d   = 1'b0;
               state_d = GET_A;
            end
         end
         default: begin
            state_d = GET_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= GET_A;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         a_m_q      <= 24'd0;
         b_m_q      <= 24'd0;
         a_e_q      <= 10'sd0;
         b_e_q      <= 10'sd0;
         z_m_q      <= 24'd0;
         z_e_q      <= 10'sd0;
         z_s_q      <= 1'b0;
         guard_q    <= 1'b0;
         round_q    <= 1'b0;
         sticky_q   <= 1'b0;
         rem_q      <= 25'd0;
         quot_q     <= 27'd0;
         cnt_q      <= 5'd0;
         z_q        <= 32'd0;
         in_a_ack_q <= 1'b0;
         in_b_ack_q <= 1'b0;
         stb_q      <= 1'b0;
         out_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         a_m_q      <= a_m_d;
         b_m_q      <= b_m_d;
         a_e_q      <= a_e_d;
         b_e_q      <= b_e_d;
         z_m_q      <= z_m_d;
         z_e_q      <= z_e_d;
         z_s_q      <= z_s_d;
         guard_q    <= guard_d;
         round_q    <= round_d;
         sticky_q   <= sticky_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         cnt_q      <= cnt_d;
         z_q        <= z_d;
         in_a_ack_q <= in_a_ack_d;
         in_b_ack_q <= in_b_ack_d;
         stb_q      <= stb_d;
         out_q      <= out_d;
      end
   end

   assign in_A_ack        = in_a_ack_q;
   assign in_B_ack        = in_b_ack_q;
   assign output_quot     = out_q;
   assign output_quot_stb = stb_q;
   assign dbg_state_o     = state_q;

endmodule
